cpu_multicycle: RTL



---
 rtl/cpu_multicycle.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_multicycle.sv
`default_nettype none
// ============================================================================
// cpu_multicycle : FETCH/DECODE/EXEC/WB multicycle CPU with req/valid fetch,
//                  internal register file, ALU and debug register read port.
// Revision       : 1.0
// ============================================================================
module cpu_multicycle #(
  parameter int              DATA_W   = 32,
  parameter int              NUM_REGS = 8,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit              ZERO_R0  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [PC_W-1:0]             imem_addr,
  input  logic                        imem_valid,
  input  logic [31:0]                 imem_rdata,
  output logic [PC_W-1:0]             pc,
  output logic                        halted,
  output logic                        illegal,
  output logic                        flag_z,
  output logic                        flag_c,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_raddr,
  output logic [DATA_W-1:0]           dbg_rdata
);

  localparam int REG_AW = $clog2(NUM_REGS);

  localparam logic [7:0] OP_LDI  = 8'h00;
  localparam logic [7:0] OP_MOV  = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_AND  = 8'h04;
  localparam logic [7:0] OP_OR   = 8'h05;
  localparam logic [7:0] OP_XOR  = 8'h06;
  localparam logic [7:0] OP_HALT = 8'h0F;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;

  logic [7:0]          op;
  logic [REG_AW-1:0]   rd;
  logic [REG_AW-1:0]   rs1;
  logic [7:0]          imm;
  logic [REG_AW-1:0]   rs2;

  logic [DATA_W-1:0]   opa;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W-1:0]   result;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic [DATA_W-1:0]   rf_rs1;
  logic [DATA_W-1:0]   rf_rs2;
  logic [DATA_W:0]     alu_wide;
  logic                op_writes;
  logic                op_sets_flags;
  logic                op_known;
  logic                rf_we;
  logic                unused_fields;

  // Register fields are 8 bits wide in the encoding; only the low REG_AW bits select.
  assign unused_fields = ^{imem_rdata[23:16], imem_rdata[15:8]};

  assign rs2           = imm[REG_AW-1:0];
  assign op_writes     = (op <= OP_XOR);
  assign op_sets_flags = (op >= OP_ADD) && (op <= OP_XOR);
  assign op_known      = op_writes || (op == OP_HALT);
  assign rf_we         = (state == S_WB) && op_writes && !(ZERO_R0 && (rd == '0));

  assign rf_rs1    = (ZERO_R0 && (rs1 == '0))       ? '0 : regs[rs1];
  assign rf_rs2    = (ZERO_R0 && (rs2 == '0))       ? '0 : regs[rs2];
  assign dbg_rdata = (ZERO_R0 && (dbg_raddr == '0)) ? '0 : regs[dbg_raddr];
  assign imem_addr = pc;

  // Extra MSB carries ADD carry-out, or SUB borrow (set iff opa < opb).
  always_comb begin
    alu_wide = '0;
    case (op)
      OP_LDI:  alu_wide = {1'b0, DATA_W'(imm)};
      OP_MOV:  alu_wide = {1'b0, opa};
      OP_ADD:  alu_wide = {1'b0, opa} + {1'b0, opb};
      OP_SUB:  alu_wide = {1'b0, opa} - {1'b0, opb};
      OP_AND:  alu_wide = {1'b0, opa & opb};
      OP_OR:   alu_wide = {1'b0, opa | opb};
      OP_XOR:  alu_wide = {1'b0, opa ^ opb};
      default: alu_wide = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   state_nx = S_WB;
      S_WB: begin
        illegal  = !op_known;
        state_nx = (op == OP_HALT) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted   = 1'b1;
        state_nx = S_HALT;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      op     <= '0;
      rd     <= '0;
      rs1    <= '0;
      imm    <= '0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            op  <= imem_rdata[31:24];
            rd  <= imem_rdata[16 +: REG_AW];
            rs1 <= imem_rdata[8 +: REG_AW];
            imm <= imem_rdata[7:0];
          end
        end
        S_DECODE: begin
          opa <= rf_rs1;
          opb <= rf_rs2;
        end
        S_EXEC: begin
          result <= alu_wide[DATA_W-1:0];
          if (op_sets_flags) begin
            flag_z <= (alu_wide[DATA_W-1:0] == '0);
            flag_c <= alu_wide[DATA_W];
          end
        end
        S_WB: begin
          pc <= pc + PC_W'(4);
        end
        default: ;
      endcase
    end
  end

  // Writes land at the WB->FETCH edge, so the next DECODE already sees them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[rd] <= result;
    end
  end

endmodule
`default_nettype wire
